// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Signal bundle between the fetch sequencer and its neighbours.
//
// Handshakes:
//   memory  : a byte transfers on a rising edge where mem_rd=1 and
//             mem_ready=1; mem_data is sampled on that edge.
//   decoder : instr_out is consumed on a rising edge where instr_valid=1
//             and instr_ack=1; instr_valid and instr_out hold until then.
//
// Modports:
//   master : the fetch sequencer (drives memory, ir and decoder outputs)
//   slave  : the environment (decoder, memory, ir model / testbench)
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    // decoder / branch side
    logic              fetch_req;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;
    logic [15:0]       instr_out;
    logic              instr_valid;
    logic              instr_ack;
    logic [ADDR_W-1:0] pc_out;
    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              mem_ready;
    // instruction register load controls
    logic              ir_enable;
    logic [1:0]        ir_funsel;
    logic              ir_lh;
    logic [7:0]        ir_data;
    // FSM state for observation (0=IDLE 1=RD_LO 2=RD_HI 3=HOLD)
    logic [1:0]        dbg_state;

    modport master (
        input  fetch_req, pc_load, pc_in, instr_ack, mem_data, mem_ready,
        output instr_out, instr_valid, pc_out, mem_addr, mem_rd,
               ir_enable, ir_funsel, ir_lh, ir_data, dbg_state
    );

    modport slave (
        output fetch_req, pc_load, pc_in, instr_ack, mem_data, mem_ready,
        input  instr_out, instr_valid, pc_out, mem_addr, mem_rd,
               ir_enable, ir_funsel, ir_lh, ir_data, dbg_state
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch sequencer. Owns the PC, reads the low then the high byte
// of a 16-bit instruction from byte-wide memory, pulses the instruction
// register load controls once per byte and offers the assembled word to the
// decoder until it is acknowledged.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high; returns to IDLE with pc=RESET_PC
//   bus    : fetch_ctrl_if.master (memory, ir, decoder and PC signals)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [15:0]       r_instr;
    logic [7:0]        r_ir_data;
    logic              r_ir_enable;
    logic              r_ir_lh;
    logic              w_mem_rd;
    logic              w_accept_lo;
    logic              w_accept_hi;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // The first RD_HI cycle is the low-byte ir pulse cycle. The read is held
    // off for that cycle so the two ir pulses can never be adjacent; this is
    // also what places instr_valid on edge N+3 for a zero-wait memory.
    always_comb begin
        w_mem_rd = 1'b0;
        if (r_state == RD_LO) begin
            w_mem_rd = 1'b1;
        end else if (r_state == RD_HI && !r_ir_enable) begin
            w_mem_rd = 1'b1;
        end
    end

    // Next-state and PC logic. pc_load wins over any byte accepted in the
    // same cycle, so an aborted fetch never increments the PC or pulses ir.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_accept_lo = 1'b0;
        w_accept_hi = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.fetch_req) begin
                    w_state_nxt = RD_LO;
                end
            end
            RD_LO: begin
                if (bus.pc_load) begin
                    w_state_nxt = IDLE;
                end else if (w_mem_rd && bus.mem_ready) begin
                    w_accept_lo = 1'b1;
                    w_pc_nxt    = r_pc + PC_ONE;
                    w_state_nxt = RD_HI;
                end
            end
            RD_HI: begin
                if (bus.pc_load) begin
                    w_state_nxt = IDLE;
                end else if (w_mem_rd && bus.mem_ready) begin
                    w_accept_hi = 1'b1;
                    w_pc_nxt    = r_pc + PC_ONE;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.pc_load) begin
                    w_state_nxt = IDLE;
                end else if (bus.instr_ack) begin
                    w_state_nxt = bus.fetch_req ? RD_LO : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (bus.pc_load) begin
            w_pc_nxt = bus.pc_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 16'h0000;
            r_ir_data   <= 8'h00;
            r_ir_enable <= 1'b0;
            r_ir_lh     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir_enable <= w_accept_lo | w_accept_hi;
            if (w_accept_lo) begin
                r_instr[7:0] <= bus.mem_data;
                r_ir_data    <= bus.mem_data;
                r_ir_lh      <= 1'b0;
            end
            if (w_accept_hi) begin
                r_instr[15:8] <= bus.mem_data;
                r_ir_data     <= bus.mem_data;
                r_ir_lh       <= 1'b1;
            end
        end
    end

    assign bus.mem_rd      = w_mem_rd;
    assign bus.mem_addr    = r_pc;
    assign bus.pc_out      = r_pc;
    assign bus.ir_enable   = r_ir_enable;
    // Only ever "load" while enabled; never clear or count the ir.
    assign bus.ir_funsel   = r_ir_enable ? 2'b01 : 2'b00;
    assign bus.ir_lh       = r_ir_lh;
    assign bus.ir_data     = r_ir_data;
    assign bus.instr_out   = r_instr;
    // HOLD is entered on the same edge that raises the high-byte ir pulse.
    assign bus.instr_valid = (r_state == HOLD);
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl: zero-wait fetch, wait states, PC wrap,
// pc_load abort, back-to-back fetch via ack, reset mid-fetch.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic clock;
    logic reset;

    fetch_ctrl_if #(.ADDR_W(8)) bus ();

    fetch_ctrl #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // byte-wide memory model, combinational read
    logic [7:0] mem [256];
    assign bus.mem_data = mem[bus.mem_addr];

    // ir pulse log {lh, data} and ir rule violations, sampled mid-cycle
    logic [8:0] pulse_q [$];
    int         viol;
    logic       prev_en;
    initial begin
        viol    = 0;
        prev_en = 1'b0;
    end
    always @(negedge clock) begin
        if (bus.ir_enable) begin
            pulse_q.push_back({bus.ir_lh, bus.ir_data});
            if (prev_en) viol++;
            if (bus.ir_funsel != 2'b01) viol++;
        end
        prev_en = bus.ir_enable;
    end

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int base;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset         = 1'b1;
        bus.fetch_req = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_in     = 8'h00;
        bus.mem_ready = 1'b0;
        bus.instr_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // ---- reset state
        check("rst_state", bus.dbg_state, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_ir_en", bus.ir_enable, 0);
        check("rst_funsel", bus.ir_funsel, 0);
        check("rst_lh", bus.ir_lh, 0);
        check("rst_ir_data", bus.ir_data, 0);
        check("rst_instr", bus.instr_out, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_pc", bus.pc_out, 8'h00);

        // ---- T1: zero-wait fetch of 1234 from address 00
        mem[8'h00] = 8'h34;
        mem[8'h01] = 8'h12;
        bus.mem_ready = 1'b1;
        base = pulse_q.size();
        bus.fetch_req = 1'b1;
        tick();                                   // edge N
        bus.fetch_req = 1'b0;
        check("t1_n_state", bus.dbg_state, 1);
        check("t1_n_rd", bus.mem_rd, 1);
        check("t1_n_addr", bus.mem_addr, 8'h00);
        tick();                                   // edge N+1
        check("t1_lo_en", bus.ir_enable, 1);
        check("t1_lo_funsel", bus.ir_funsel, 2'b01);
        check("t1_lo_lh", bus.ir_lh, 0);
        check("t1_lo_data", bus.ir_data, 8'h34);
        check("t1_lo_pc", bus.pc_out, 8'h01);
        check("t1_lo_valid", bus.instr_valid, 0);
        tick();                                   // edge N+2
        check("t1_gap_en", bus.ir_enable, 0);
        check("t1_gap_rd", bus.mem_rd, 1);
        check("t1_gap_addr", bus.mem_addr, 8'h01);
        check("t1_gap_valid", bus.instr_valid, 0);
        tick();                                   // edge N+3
        check("t1_hi_en", bus.ir_enable, 1);
        check("t1_hi_lh", bus.ir_lh, 1);
        check("t1_hi_data", bus.ir_data, 8'h12);
        check("t1_valid", bus.instr_valid, 1);
        check("t1_instr", bus.instr_out, 16'h1234);
        check("t1_pc", bus.pc_out, 8'h02);
        check("t1_hold_rd", bus.mem_rd, 0);
        tick();
        check("t1_hold_stable", bus.instr_out, 16'h1234);
        check("t1_hold_valid", bus.instr_valid, 1);
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;
        check("t1_ack_valid", bus.instr_valid, 0);
        check("t1_ack_state", bus.dbg_state, 0);
        check("t1_npulse", pulse_q.size() - base, 2);
        check("t1_p0", pulse_q[base], {1'b0, 8'h34});
        check("t1_p1", pulse_q[base+1], {1'b1, 8'h12});

        // ---- T2: three wait cycles on the low byte
        bus.pc_load = 1'b1;
        bus.pc_in   = 8'h00;
        tick();
        bus.pc_load = 1'b0;
        check("t2_pc_load", bus.pc_out, 8'h00);
        check("t2_idle", bus.dbg_state, 0);
        bus.mem_ready = 1'b0;
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_rd", bus.mem_rd, 1);
            check("t2_wait_addr", bus.mem_addr, 8'h00);
            check("t2_wait_en", bus.ir_enable, 0);
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        check("t2_lo_en", bus.ir_enable, 1);
        check("t2_lo_data", bus.ir_data, 8'h34);
        tick();
        tick();
        check("t2_valid", bus.instr_valid, 1);
        check("t2_instr", bus.instr_out, 16'h1234);
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;

        // ---- T3: PC wrap from FF to 00
        mem[8'hFF] = 8'hCD;
        mem[8'h00] = 8'hAB;
        bus.pc_load = 1'b1;
        bus.pc_in   = 8'hFF;
        tick();
        bus.pc_load = 1'b0;
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("t3_addr_lo", bus.mem_addr, 8'hFF);
        check("t3_rd_lo", bus.mem_rd, 1);
        tick();
        check("t3_lo_data", bus.ir_data, 8'hCD);
        check("t3_pc_wrap", bus.pc_out, 8'h00);
        tick();
        check("t3_addr_hi", bus.mem_addr, 8'h00);
        check("t3_rd_hi", bus.mem_rd, 1);
        tick();
        check("t3_valid", bus.instr_valid, 1);
        check("t3_instr", bus.instr_out, 16'hABCD);
        check("t3_pc", bus.pc_out, 8'h01);
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;

        // ---- T4: pc_load during RD_HI wait aborts; same-cycle byte dropped
        mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h99;
        base = pulse_q.size();
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();                                   // low byte 12 accepted
        bus.mem_ready = 1'b0;
        tick();
        check("t4_rd_hi_state", bus.dbg_state, 2);
        check("t4_rd_hi_addr", bus.mem_addr, 8'h02);
        bus.pc_load   = 1'b1;
        bus.pc_in     = 8'h40;
        bus.mem_ready = 1'b1;
        tick();
        bus.pc_load   = 1'b0;
        bus.mem_ready = 1'b0;
        check("t4_abort_state", bus.dbg_state, 0);
        check("t4_abort_pc", bus.pc_out, 8'h40);
        check("t4_abort_rd", bus.mem_rd, 0);
        check("t4_abort_en", bus.ir_enable, 0);
        check("t4_abort_valid", bus.instr_valid, 0);
        check("t4_partial", bus.instr_out, 16'hAB12);
        tick();
        tick();
        check("t4_late_valid", bus.instr_valid, 0);
        check("t4_npulse", pulse_q.size() - base, 1);
        check("t4_p0", pulse_q[base], {1'b0, 8'h12});

        // ---- T5: ack + fetch_req in HOLD gives back-to-back instructions
        mem[8'h00] = 8'h34;
        mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h78;
        mem[8'h03] = 8'h56;
        bus.pc_load = 1'b1;
        bus.pc_in   = 8'h00;
        tick();
        bus.pc_load   = 1'b0;
        bus.mem_ready = 1'b1;
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        tick();
        tick();
        tick();
        check("t5_first_valid", bus.instr_valid, 1);
        check("t5_first_instr", bus.instr_out, 16'h1234);
        bus.instr_ack = 1'b1;
        bus.fetch_req = 1'b1;
        tick();
        bus.instr_ack = 1'b0;
        bus.fetch_req = 1'b0;
        check("t5_ack_valid", bus.instr_valid, 0);
        check("t5_refetch_state", bus.dbg_state, 1);
        check("t5_refetch_rd", bus.mem_rd, 1);
        check("t5_refetch_addr", bus.mem_addr, 8'h02);
        tick();
        tick();
        tick();
        check("t5_second_valid", bus.instr_valid, 1);
        check("t5_second_instr", bus.instr_out, 16'h5678);
        check("t5_second_pc", bus.pc_out, 8'h04);
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;

        // ---- T6: reset during RD_LO wait
        bus.mem_ready = 1'b0;
        base = pulse_q.size();
        bus.fetch_req = 1'b1;
        tick();
        bus.fetch_req = 1'b0;
        check("t6_rd_lo", bus.dbg_state, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_state", bus.dbg_state, 0);
        check("t6_pc", bus.pc_out, 8'h00);
        check("t6_rd", bus.mem_rd, 0);
        check("t6_en", bus.ir_enable, 0);
        check("t6_funsel", bus.ir_funsel, 0);
        check("t6_lh", bus.ir_lh, 0);
        check("t6_ir_data", bus.ir_data, 0);
        check("t6_instr", bus.instr_out, 0);
        check("t6_valid", bus.instr_valid, 0);
        bus.mem_ready = 1'b1;
        tick();
        tick();
        check("t6_no_pulse_en", bus.ir_enable, 0);
        check("t6_npulse", pulse_q.size() - base, 0);
        check("t6_idle", bus.dbg_state, 0);

        // ---- ir pulse rules over the whole run
        check("ir_rules", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
